// File: rtl/btb_branch_predictor_pkg.sv
// Shared defaults, counter encodings and tag-width helper for the BTB next-PC predictor.
package bp_pkg;

  localparam int BP_ENTRYBITS = 6;
  localparam int BP_CTRBITS   = 2;
  localparam int BP_STATBITS  = 16;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr2_e;

  function automatic int tag_bits(input int dbits, input int entrybits);
    return dbits - entrybits - 2;
  endfunction

endpackage

// File: rtl/btb_branch_predictor_if.sv
// Fetch lookup, EX update, flush and debug statistics bundle of the BTB predictor.
interface btb_branch_predictor_if #(
  parameter int DBITS    = 32,
  parameter int STATBITS = 16
);
  logic [DBITS-1:0]    pc_FE;
  logic [DBITS-1:0]    pcpred_FE;
  logic                hit_FE;
  logic                predtaken_FE;
  logic                upd_valid;
  logic [DBITS-1:0]    upd_pc;
  logic                upd_is_br;
  logic                upd_is_jmp;
  logic                upd_taken;
  logic [DBITS-1:0]    upd_target;
  logic                upd_mispred;
  logic                flush;
  logic [STATBITS-1:0] stat_ctrl;
  logic [STATBITS-1:0] stat_mispred;

  modport master (
    output pc_FE, upd_valid, upd_pc, upd_is_br, upd_is_jmp, upd_taken,
           upd_target, upd_mispred, flush,
    input  pcpred_FE, hit_FE, predtaken_FE, stat_ctrl, stat_mispred
  );

  modport slave (
    input  pc_FE, upd_valid, upd_pc, upd_is_br, upd_is_jmp, upd_taken,
           upd_target, upd_mispred, flush,
    output pcpred_FE, hit_FE, predtaken_FE, stat_ctrl, stat_mispred
  );
endinterface

// File: rtl/btb_branch_predictor_sat_ctr.sv
// Combinational next value of a saturating direction counter; force_max wins over inc/dec.
module bp_sat_ctr #(
  parameter int CTRBITS = 2
) (
  input  logic [CTRBITS-1:0] cur_i,
  input  logic               inc_i,
  input  logic               force_max_i,
  output logic [CTRBITS-1:0] nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    if (force_max_i) begin
      nxt_o = '1;
    end else if (inc_i) begin
      if (cur_i != '1) nxt_o = cur_i + 1'b1;
    end else begin
      if (cur_i != '0) nxt_o = cur_i - 1'b1;
    end
  end

endmodule

// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: zero-latency lookup on the fetch PC,
// table update from EX on the rising edge, single-cycle flush, saturating debug statistics.
module btb_branch_predictor
  import bp_pkg::*;
#(
  parameter int DBITS     = 32,
  parameter int INSTSIZE  = 4,
  parameter int ENTRYBITS = BP_ENTRYBITS,
  parameter int CTRBITS   = BP_CTRBITS,
  parameter int STATBITS  = BP_STATBITS
) (
  input logic                   clk,
  input logic                   RESET_N,
  btb_branch_predictor_if.slave bp
);

  localparam int                 TAGBITS    = tag_bits(DBITS, ENTRYBITS);
  localparam int                 NENT       = 1 << ENTRYBITS;
  localparam logic [DBITS-1:0]   PC_INC     = DBITS'(INSTSIZE);
  localparam logic [CTRBITS-1:0] CTR_WEAK_T = CTRBITS'(1 << (CTRBITS - 1));

  logic [NENT-1:0]     valid_q, valid_d;
  logic [TAGBITS-1:0]  tag_q [NENT];
  logic [DBITS-1:0]    tgt_q [NENT];
  logic [CTRBITS-1:0]  ctr_q [NENT];
  logic [STATBITS-1:0] stat_ctrl_q, stat_ctrl_d;
  logic [STATBITS-1:0] stat_mis_q, stat_mis_d;

  logic [ENTRYBITS-1:0] lk_idx, ud_idx;
  logic [TAGBITS-1:0]   lk_tag, ud_tag;
  logic                 lk_hit, lk_taken, ud_hit, counted;
  logic                 wr_en, tgt_we;
  logic [CTRBITS-1:0]   ctr_nxt, ctr_d;
  logic                 unused_pc_lo;

  assign lk_idx = bp.pc_FE[ENTRYBITS+1:2];
  assign lk_tag = bp.pc_FE[DBITS-1:ENTRYBITS+2];
  assign ud_idx = bp.upd_pc[ENTRYBITS+1:2];
  assign ud_tag = bp.upd_pc[DBITS-1:ENTRYBITS+2];
  assign unused_pc_lo = ^{bp.pc_FE[1:0], bp.upd_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not visible here.
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][CTRBITS-1];

  assign bp.hit_FE       = lk_hit;
  assign bp.predtaken_FE = lk_taken;
  assign bp.pcpred_FE    = lk_taken ? tgt_q[lk_idx] : bp.pc_FE + PC_INC;
  assign bp.stat_ctrl    = stat_ctrl_q;
  assign bp.stat_mispred = stat_mis_q;

  assign counted = bp.upd_valid && (bp.upd_is_br || bp.upd_is_jmp);
  assign ud_hit  = valid_q[ud_idx] && (tag_q[ud_idx] == ud_tag);

  bp_sat_ctr #(.CTRBITS(CTRBITS)) u_sat_ctr (
    .cur_i       (ctr_q[ud_idx]),
    .inc_i       (bp.upd_taken),
    .force_max_i (bp.upd_is_jmp),
    .nxt_o       (ctr_nxt)
  );

  always_comb begin
    valid_d = valid_q;
    wr_en   = 1'b0;
    tgt_we  = 1'b0;
    ctr_d   = ctr_nxt;
    if (bp.flush) begin
      valid_d = '0;
    end else if (counted) begin
      if (ud_hit) begin
        wr_en  = 1'b1;
        tgt_we = bp.upd_taken || bp.upd_is_jmp;
      end else if (bp.upd_taken) begin
        wr_en           = 1'b1;
        tgt_we          = 1'b1;
        valid_d[ud_idx] = 1'b1;
        ctr_d           = bp.upd_is_jmp ? '1 : CTR_WEAK_T;
      end
    end
  end

  // Statistics count every resolved branch/JAL, including one dropped by a flush.
  always_comb begin
    stat_ctrl_d = stat_ctrl_q;
    stat_mis_d  = stat_mis_q;
    if (counted && !(&stat_ctrl_q)) stat_ctrl_d = stat_ctrl_q + 1'b1;
    if (counted && bp.upd_mispred && !(&stat_mis_q)) stat_mis_d = stat_mis_q + 1'b1;
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_q     <= '0;
      stat_ctrl_q <= '0;
      stat_mis_q  <= '0;
      for (int i = 0; i < NENT; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      stat_ctrl_q <= stat_ctrl_d;
      stat_mis_q  <= stat_mis_d;
      if (wr_en) begin
        tag_q[ud_idx] <= ud_tag;
        ctr_q[ud_idx] <= ctr_d;
        if (tgt_we) tgt_q[ud_idx] <= bp.upd_target;
      end
    end
  end

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Directed bench for btb_branch_predictor: stimulus pushes expected lookups, a negedge monitor checks them.
module tb_btb_branch_predictor;

  typedef struct {
    logic        hit;
    logic        pt;
    logic [31:0] pcp;
    logic [15:0] sc;
    logic [15:0] sm;
  } exp_t;

  logic clk = 1'b0;
  logic RESET_N = 1'b0;
  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] exp_ctrl = '0;
  logic [15:0] exp_mis = '0;

  btb_branch_predictor_if #(.DBITS(32), .STATBITS(16)) bp_if();

  btb_branch_predictor dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .bp      (bp_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, want, $time);
    end
  endtask

  // Monitor: one expected entry per presented lookup cycle.
  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow @%0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hit_FE", {31'd0, bp_if.hit_FE}, {31'd0, e.hit});
        chk("predtaken_FE", {31'd0, bp_if.predtaken_FE}, {31'd0, e.pt});
        chk("pcpred_FE", bp_if.pcpred_FE, e.pcp);
        chk("stat_ctrl", {16'd0, bp_if.stat_ctrl}, {16'd0, e.sc});
        chk("stat_mispred", {16'd0, bp_if.stat_mispred}, {16'd0, e.sm});
      end
    end
  end

  // Expected stats advance on the edge that applies a counted update.
  task automatic tick();
    @(posedge clk);
    if (RESET_N && bp_if.upd_valid && (bp_if.upd_is_br || bp_if.upd_is_jmp)) begin
      if (exp_ctrl != 16'hffff) exp_ctrl++;
      if (bp_if.upd_mispred && exp_mis != 16'hffff) exp_mis++;
    end
    #1;
    chk_vld         = 1'b0;
    bp_if.upd_valid = 1'b0;
    bp_if.flush     = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tgt, input logic mis);
    bp_if.upd_valid   = 1'b1;
    bp_if.upd_pc      = pc;
    bp_if.upd_is_br   = br;
    bp_if.upd_is_jmp  = jmp;
    bp_if.upd_taken   = tk;
    bp_if.upd_target  = tgt;
    bp_if.upd_mispred = mis;
  endtask

  task automatic upd(input logic [31:0] pc, input logic br, input logic jmp,
                     input logic tk, input logic [31:0] tgt, input logic mis);
    set_upd(pc, br, jmp, tk, tgt, mis);
    tick();
  endtask

  task automatic look(input logic [31:0] pc, input logic hit, input logic pt, input logic [31:0] pcp);
    exp_t e;
    bp_if.pc_FE = pc;
    e.hit = hit; e.pt = pt; e.pcp = pcp; e.sc = exp_ctrl; e.sm = exp_mis;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    tick();
  endtask

  initial begin
    exp_t e;
    bp_if.pc_FE = 32'h100;
    bp_if.upd_valid = 1'b0; bp_if.upd_pc = '0; bp_if.upd_is_br = 1'b0;
    bp_if.upd_is_jmp = 1'b0; bp_if.upd_taken = 1'b0; bp_if.upd_target = '0;
    bp_if.upd_mispred = 1'b0; bp_if.flush = 1'b0;
    @(posedge clk); #1;
    look(32'h100, 1'b0, 1'b0, 32'h104);
    RESET_N = 1'b1;
    look(32'h100, 1'b0, 1'b0, 32'h104);

    // Allocate, then walk the counter through both saturation limits.
    upd(32'h100, 1, 0, 1, 32'h200, 1);
    look(32'h100, 1, 1, 32'h200);
    look(32'h102, 1, 1, 32'h200);
    upd(32'h100, 1, 0, 0, 32'h0, 0);
    look(32'h100, 1, 0, 32'h104);
    upd(32'h100, 1, 0, 0, 32'h0, 0);
    look(32'h100, 1, 0, 32'h104);
    upd(32'h100, 1, 0, 0, 32'h0, 0);
    upd(32'h100, 1, 0, 1, 32'h204, 0);
    look(32'h100, 1, 0, 32'h104);
    upd(32'h100, 1, 0, 1, 32'h204, 0);
    look(32'h100, 1, 1, 32'h204);
    upd(32'h100, 1, 0, 1, 32'h204, 0);
    upd(32'h100, 1, 0, 1, 32'h204, 0);
    look(32'h100, 1, 1, 32'h204);
    upd(32'h100, 1, 0, 0, 32'h0, 0);
    look(32'h100, 1, 1, 32'h204);

    // Alias replaces entry 0; a not-taken miss leaves it alone.
    upd(32'h200, 1, 0, 1, 32'h300, 0);
    look(32'h100, 0, 0, 32'h104);
    look(32'h200, 1, 1, 32'h300);
    upd(32'h100, 1, 0, 0, 32'h999, 0);
    look(32'h200, 1, 1, 32'h300);

    // Same-cycle lookup sees pre-update contents.
    set_upd(32'h200, 1, 0, 0, 32'h0, 0);
    look(32'h200, 1, 1, 32'h300);
    look(32'h200, 1, 0, 32'h204);

    // JAL, ignored update, then flush racing an update.
    upd(32'h140, 0, 1, 1, 32'h400, 1);
    look(32'h140, 1, 1, 32'h400);
    upd(32'h140, 0, 0, 1, 32'h500, 1);
    look(32'h140, 1, 1, 32'h400);
    bp_if.flush = 1'b1;
    upd(32'h180, 1, 0, 1, 32'h600, 0);
    look(32'h140, 0, 0, 32'h144);
    look(32'h180, 0, 0, 32'h184);
    look(32'h200, 0, 0, 32'h204);

    // Statistics saturation.
    for (int i = 0; i < 65539; i++) upd(32'h300, 1, 0, 1, 32'h700, 1);
    look(32'h300, 1, 1, 32'h700);

    // Asynchronous reset mid-update: outputs return to reset values before the next edge.
    set_upd(32'h300, 1, 0, 1, 32'h800, 1);
    bp_if.pc_FE = 32'h300;
    #2;
    RESET_N = 1'b0;
    exp_ctrl = '0;
    exp_mis = '0;
    e.hit = 1'b0; e.pt = 1'b0; e.pcp = 32'h304; e.sc = 16'h0; e.sm = 16'h0;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    tick();
    RESET_N = 1'b1;
    look(32'h300, 0, 0, 32'h304);

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_branch_predictor.md
Name: btb_branch_predictor

Overview:
Parametrised next-PC predictor for the FE stage of the 5-stage pipeline. It replaces the fixed "PC + INSTSIZE" prediction with a direct-mapped branch target buffer (BTB) and saturating direction counters. Lookup is combinational on the fetch PC. The table is updated from the EX stage when a branch or JAL resolves. Saturating statistics counters are exposed for HEX/LEDR debug.

Parameters:
DBITS, 32, address/data width
INSTSIZE, 4, PC increment in bytes
ENTRYBITS, 6, log2 of BTB entries (64 entries)
CTRBITS, 2, direction counter width (must be >= 1)
STATBITS, 16, width of each statistics counter
TAGBITS, DBITS-ENTRYBITS-2, derived tag width; not overridden

Ports:
clk  in  1  pipeline clock; all state changes on rising edge
RESET_N  in  1  asynchronous, active-low reset
pc_FE  in  DBITS  current fetch PC
pcpred_FE  out  DBITS  predicted next PC
hit_FE  out  1  lookup hit a valid entry with matching tag
predtaken_FE  out  1  prediction is taken
upd_valid  in  1  EX has a resolved control-flow instruction this cycle
upd_pc  in  DBITS  PC of the resolved instruction
upd_is_br  in  1  resolved instruction is a conditional branch
upd_is_jmp  in  1  resolved instruction is JAL
upd_taken  in  1  actual outcome (1 for JAL)
upd_target  in  DBITS  actual taken target
upd_mispred  in  1  EX detected a misprediction
flush  in  1  synchronous invalidate of the whole table
stat_ctrl  out  STATBITS  resolved control-flow count
stat_mispred  out  STATBITS  misprediction count

Behaviour:
- Addressing:
  - index = pc[ENTRYBITS+1:2]
  - tag = pc[DBITS-1:ENTRYBITS+2]
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target (DBITS), counter (CTRBITS).
- Lookup (combinational, zero latency):
  - hit_FE = valid[idx] && tag match.
  - predtaken_FE = hit_FE && counter MSB.
  - pcpred_FE = predtaken_FE ? target : pc_FE + INSTSIZE (modulo 2^DBITS, wraps silently).
- Update, on posedge when upd_valid && (upd_is_br || upd_is_jmp):
  - Tag hit, branch: counter saturating +1 if taken, saturating -1 if not taken. If taken, target <= upd_target; if not taken, target is unchanged.
  - Tag hit, JAL: counter <= all-ones; target <= upd_target.
  - Tag miss (or invalid entry), upd_taken=1: allocate/replace. valid=1, tag, target. Counter = 1 followed by zeros (weakly taken) for a branch, all-ones for JAL.
  - Tag miss, upd_taken=0: no table change.
- Ignored update: upd_valid with both upd_is_br and upd_is_jmp low leaves the table and stats untouched.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. There is no write-through bypass.
- Flush: on posedge, all valid bits clear. Flush has priority over a simultaneous update; that update is dropped from the table but still counted in stats.
- Statistics:
  - stat_ctrl increments on every counted update.
  - stat_mispred increments when a counted update has upd_mispred=1.
  - Both saturate at all-ones; no wrap.
- Reset (RESET_N low, asynchronous):
  - All valid=0, counters=0, targets and tags=0, stats=0.
  - During and after reset: hit_FE=0, predtaken_FE=0, pcpred_FE=pc_FE+INSTSIZE.
- Reset asserted mid-update: the update is lost; reset state wins immediately.
- Storage: valid bits in flops (needed for single-cycle flush). Tag/target/counter arrays may be inferred RAM, but reads must stay asynchronous.

Decomposition:
- Shared package bp_pkg holds:
  - default ENTRYBITS/CTRBITS/STATBITS
  - counter encodings CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3 (for CTRBITS=2)
  - function computing TAGBITS.
- Sub-module bp_sat_ctr: combinational next-value of a CTRBITS saturating counter. Inputs: current value, inc/dec, force-max. It is instantiated once on the update path.

Test Plan:
- Reset then pc_FE=0x100 -> hit_FE=0, pcpred_FE=0x104, stats=0.
- Update pc=0x100, is_br, taken, target=0x200 -> next cycle pc_FE=0x100 gives hit_FE=1, predtaken_FE=1, pcpred_FE=0x200.
- Two further not-taken updates at 0x100 (counter 2->1->0) -> predtaken_FE=0, pcpred_FE=0x104, hit_FE=1. A further not-taken keeps the counter at 0. Three taken updates saturate it at 3.
- Alias: allocate 0x100 (taken), then taken update pc=0x100+(1<<(ENTRYBITS+2)) target 0x300 -> lookup 0x100 misses and gives 0x104; lookup of the alias gives 0x300.
- JAL update pc=0x140 target 0x400, then flush together with an update at pc=0x180 -> both lookups miss afterwards; stat_ctrl counts both updates.
- 2^STATBITS+3 updates with upd_mispred=1, with RESET_N pulsed low mid-stream in a separate run -> stat_mispred holds all-ones; the reset run shows all outputs back to reset values asynchronously, before the next clock edge.
